// File: rtl/fighter_pkg.sv
// Shared types, default key bindings and small helpers for fighter_ctrl.
// KNOCK is only reachable when FIGHTER_KNOCKBACK_EN is defined.
package fighter_pkg;

    typedef enum logic [2:0] {
        IDLE, WALK, AIR, PUNCH, KICK, BLOCK, COOLDOWN, KNOCK
    } fighter_state_t;

    typedef logic signed [9:0] pos_t;

    localparam int TMR_W = 8;

    localparam logic [7:0] K_JUMP  = 8'h1a;
    localparam logic [7:0] K_LEFT  = 8'h04;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_PUNCH = 8'h15;
    localparam logic [7:0] K_KICK  = 8'h09;
    localparam logic [7:0] K_BLOCK = 8'h16;

    function automatic logic key_down(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] k
    );
        return (a == k) || (b == k);
    endfunction

    function automatic logic signed [10:0] sx(input logic [9:0] v);
        return $signed({v[9], v});
    endfunction

    function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? -v : v;
    endfunction

endpackage

// File: rtl/fighter_attack_fsm.sv
// Fighter state register, attack/cooldown timer and sprite flag decode.
// Knockback handling is compiled in with FIGHTER_KNOCKBACK_EN.
module fighter_attack_fsm
    import fighter_pkg::*;
#(
    parameter int PUNCH_FRAMES    = 8,
    parameter int KICK_FRAMES     = 12,
    parameter int COOLDOWN_FRAMES = 6
`ifdef FIGHTER_KNOCKBACK_EN
    , parameter int KNOCK_FRAMES  = 6
`endif
) (
    input  logic           frame_clk,
    input  logic           Reset_n,
    input  logic           freeze,
    input  logic           do_kick,
    input  logic           do_punch,
    input  logic           do_block,
    input  logic           do_jump,
    input  logic           do_walk,
    input  logic           land,
`ifdef FIGHTER_KNOCKBACK_EN
    input  logic           hit_in,
`endif
    output fighter_state_t st,
    output fighter_state_t nxt,
    output logic           punch_flag,
    output logic           kick_flag,
    output logic           block_flag,
    output logic           hit_active
);

    localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] P_HALF  = TMR_W'(PUNCH_FRAMES / 2);
    localparam logic [TMR_W-1:0] K_HALF  = TMR_W'(KICK_FRAMES / 2);

    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            st  <= IDLE;
            tmr <= '0;
        end else begin
            st  <= nxt;
            tmr <= tmr_n;
        end
    end

    always_comb begin
        nxt   = st;
        tmr_n = tmr;
        if (freeze) begin
            nxt   = IDLE;
            tmr_n = '0;
        end
`ifdef FIGHTER_KNOCKBACK_EN
        else if (hit_in && st != BLOCK) begin
            nxt   = KNOCK;
            tmr_n = TMR_W'(KNOCK_FRAMES);
        end
`endif
        else begin
            unique case (st)
                IDLE, WALK: begin
                    if (do_kick) begin
                        nxt   = KICK;
                        tmr_n = TMR_W'(KICK_FRAMES);
                    end else if (do_punch) begin
                        nxt   = PUNCH;
                        tmr_n = TMR_W'(PUNCH_FRAMES);
                    end else if (do_block) begin
                        nxt = BLOCK;
                    end else if (do_jump) begin
                        nxt = AIR;
                    end else if (do_walk) begin
                        nxt = WALK;
                    end else begin
                        nxt = IDLE;
                    end
                end
                AIR: if (land) nxt = IDLE;
                PUNCH, KICK: begin
                    if (tmr <= T_ONE) begin
                        nxt   = COOLDOWN;
                        tmr_n = TMR_W'(COOLDOWN_FRAMES);
                    end else begin
                        tmr_n = tmr - T_ONE;
                    end
                end
                COOLDOWN: begin
                    if (tmr <= T_ONE) begin
                        nxt   = IDLE;
                        tmr_n = '0;
                    end else begin
                        tmr_n = tmr - T_ONE;
                    end
                end
                BLOCK: if (!do_block) nxt = IDLE;
`ifdef FIGHTER_KNOCKBACK_EN
                KNOCK: begin
                    if (tmr <= T_ONE) begin
                        nxt   = IDLE;
                        tmr_n = '0;
                    end else begin
                        tmr_n = tmr - T_ONE;
                    end
                end
`endif
                default: begin
                    nxt   = IDLE;
                    tmr_n = '0;
                end
            endcase
        end
    end

    assign punch_flag = (st == PUNCH);
    assign kick_flag  = (st == KICK);
    assign block_flag = (st == BLOCK);
    assign hit_active = (tmr != '0) &&
                        (((st == PUNCH) && (tmr <= P_HALF)) ||
                         ((st == KICK)  && (tmr <= K_HALF)));

endmodule

// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: kinematics, wall/opponent clamps, attack FSM.
// Define FIGHTER_KNOCKBACK_EN to add the hit_in port and the KNOCK state.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int X_CENTER        = 150,
    parameter int Y_GROUND        = 360,
    parameter int X_MIN           = 3,
    parameter int X_MAX           = 549,
    parameter int BODY_L          = 45,
    parameter int BODY_R          = 45,
    parameter int BODY_U          = 90,
    parameter int BODY_D          = 60,
    parameter int WALK_STEP       = 3,
    parameter int GRAVITY         = 3,
    parameter int JUMP_VEL        = 30,
    parameter int PUNCH_FRAMES    = 8,
    parameter int KICK_FRAMES     = 12,
    parameter int COOLDOWN_FRAMES = 6,
    parameter logic [7:0] KEY_JUMP  = K_JUMP,
    parameter logic [7:0] KEY_LEFT  = K_LEFT,
    parameter logic [7:0] KEY_RIGHT = K_RIGHT,
    parameter logic [7:0] KEY_PUNCH = K_PUNCH,
    parameter logic [7:0] KEY_KICK  = K_KICK,
    parameter logic [7:0] KEY_BLOCK = K_BLOCK
`ifdef FIGHTER_KNOCKBACK_EN
    , parameter int KNOCK_FRAMES    = 6
`endif
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic [7:0]        keycode,
    input  logic [7:0]        keycode2,
    input  logic              freeze,
    input  logic [9:0]        opp_x,
    input  logic [9:0]        opp_y,
`ifdef FIGHTER_KNOCKBACK_EN
    input  logic              hit_in,
`endif
    output logic signed [9:0] pos_x,
    output logic signed [9:0] pos_y,
    output logic signed [9:0] vel_x,
    output logic              face_right,
    output logic              punch_flag,
    output logic              kick_flag,
    output logic              block_flag,
    output logic              hit_active,
    output logic [2:0]        state
);

    localparam logic signed [10:0] X_LO    = 11'(X_MIN + BODY_L);
    localparam logic signed [10:0] X_HI    = 11'(X_MAX - BODY_R);
    localparam logic signed [10:0] Y_GND   = 11'(Y_GROUND);
    localparam logic signed [10:0] STEP    = 11'(WALK_STEP);
    localparam logic signed [10:0] GRAV    = 11'(GRAVITY);
    localparam logic signed [10:0] REACH_X = 11'(BODY_L + BODY_R);
    localparam logic signed [10:0] REACH_Y = 11'(BODY_U + BODY_D);
    localparam pos_t X0      = 10'(X_CENTER);
    localparam pos_t Y0      = 10'(Y_GROUND);
    localparam pos_t VY_JUMP = 10'(-JUMP_VEL);

    fighter_state_t st, nxt;
    pos_t vy, vy_n, x_n, y_n, vx_n;
    logic left, right, land, v_ov, ov_now, move_ok, knock, face_n;
    logic signed [10:0] dx, dy, dn, step, push, d, xsum, vy_air, ysum;

    assign left  = key_down(keycode, keycode2, KEY_LEFT);
    assign right = key_down(keycode, keycode2, KEY_RIGHT);

    fighter_attack_fsm #(
        .PUNCH_FRAMES    (PUNCH_FRAMES),
        .KICK_FRAMES     (KICK_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
`ifdef FIGHTER_KNOCKBACK_EN
        , .KNOCK_FRAMES  (KNOCK_FRAMES)
`endif
    ) u_fsm (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .freeze     (freeze),
        .do_kick    (key_down(keycode, keycode2, KEY_KICK)),
        .do_punch   (key_down(keycode, keycode2, KEY_PUNCH)),
        .do_block   (key_down(keycode, keycode2, KEY_BLOCK)),
        .do_jump    (key_down(keycode, keycode2, KEY_JUMP)),
        .do_walk    (left || right),
        .land       (land),
`ifdef FIGHTER_KNOCKBACK_EN
        .hit_in     (hit_in),
`endif
        .st         (st),
        .nxt        (nxt),
        .punch_flag (punch_flag),
        .kick_flag  (kick_flag),
        .block_flag (block_flag),
        .hit_active (hit_active)
    );

    always_comb begin
        dx      = sx(pos_x) - sx(opp_x);
        dy      = sx(pos_y) - sx(opp_y);
        v_ov    = abs11(dy) < REACH_Y;
        ov_now  = v_ov && (abs11(dx) < REACH_X);
        push    = dx[10] ? -STEP : STEP;
        step    = '0;
        if (right && !left) step = STEP;
        else if (left && !right) step = -STEP;
        dn      = dx + step;
        move_ok = nxt inside {IDLE, WALK, AIR, COOLDOWN};
        knock   = (nxt == KNOCK);
        d       = '0;
        if (freeze) begin
            d = '0;
        end else if (knock || (move_ok && ov_now)) begin
            d = push;
        end else if (move_ok) begin
            d = step;
            // refuse a step that would carry us into the opponent
            if (step != '0 && v_ov && abs11(dn) < REACH_X &&
                step[10] != dx[10])
                d = '0;
        end
        xsum = sx(pos_x) + d;
        if (freeze) x_n = pos_x;
        else if (xsum < X_LO) x_n = X_LO[9:0];
        else if (xsum > X_HI) x_n = X_HI[9:0];
        else x_n = xsum[9:0];
        vx_n = x_n - pos_x;

        vy_air = sx(vy) + GRAV;
        ysum   = sx(pos_y) + vy_air;
        land   = (st == AIR) && (ysum >= Y_GND);
        y_n    = pos_y;
        vy_n   = vy;
        if (freeze) begin
            vy_n = '0;
        end else if (st == AIR) begin
            y_n  = land ? Y0 : ysum[9:0];
            vy_n = land ? '0 : vy_air[9:0];
        end else if (nxt == AIR) begin
            vy_n = VY_JUMP;
            y_n  = pos_y + VY_JUMP;
        end

        face_n = face_right;
        if (nxt inside {IDLE, WALK, AIR})
            face_n = sx(opp_x) > sx(x_n);
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            pos_x      <= X0;
            pos_y      <= Y0;
            vel_x      <= '0;
            vy         <= '0;
            face_right <= 1'b1;
        end else begin
            pos_x      <= x_n;
            pos_y      <= y_n;
            vel_x      <= vx_n;
            vy         <= vy_n;
            face_right <= face_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Self-checking bench for fighter_ctrl: directed scenarios plus random play
// against a frame-level reference model.
module tb_fighter_ctrl;
    import fighter_pkg::*;

    localparam logic [7:0] KEYJ = 8'h1a;
    localparam logic [7:0] KEYL = 8'h04;
    localparam logic [7:0] KEYR = 8'h07;
    localparam logic [7:0] KEYP = 8'h15;
    localparam logic [7:0] KEYK = 8'h09;
    localparam logic [7:0] KEYB = 8'h16;

    logic clk = 1'b0;
    logic Reset_n, freeze, hit_in;
    logic [7:0] keycode, keycode2;
    logic [9:0] opp_x, opp_y;
    logic signed [9:0] pos_x, pos_y, vel_x;
    logic face_right, punch_flag, kick_flag, block_flag, hit_active;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    int m_x, m_y, m_vy, m_vel, m_tmr;
    bit m_face;
    fighter_state_t m_st;

    always #5 clk = ~clk;

    fighter_ctrl dut (
        .frame_clk  (clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .keycode2   (keycode2),
        .freeze     (freeze),
        .opp_x      (opp_x),
        .opp_y      (opp_y),
`ifdef FIGHTER_KNOCKBACK_EN
        .hit_in     (hit_in),
`endif
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vel_x      (vel_x),
        .face_right (face_right),
        .punch_flag (punch_flag),
        .kick_flag  (kick_flag),
        .block_flag (block_flag),
        .hit_active (hit_active),
        .state      (state)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit down(input logic [7:0] k);
        return keycode == k || keycode2 == k;
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = 150; m_y = 360; m_vy = 0; m_vel = 0; m_tmr = 0;
        m_face = 1; m_st = IDLE;
    endtask

    // One frame of the game rules, in plain integers.
    task automatic model_step();
        fighter_state_t ns;
        int nt, want, gap, d, nx, v;
        bit hit, vov, free_mv;
        hit = 0;
`ifdef FIGHTER_KNOCKBACK_EN
        hit = hit_in;
`endif
        ns = m_st; nt = m_tmr;
        if (freeze) begin
            ns = IDLE; nt = 0;
        end else if (hit && m_st != BLOCK) begin
            ns = KNOCK; nt = 6;
        end else begin
            case (m_st)
                IDLE, WALK: begin
                    if (down(KEYK)) begin ns = KICK; nt = 12; end
                    else if (down(KEYP)) begin ns = PUNCH; nt = 8; end
                    else if (down(KEYB)) ns = BLOCK;
                    else if (down(KEYJ)) ns = AIR;
                    else if (down(KEYL) || down(KEYR)) ns = WALK;
                    else ns = IDLE;
                end
                AIR: if (m_y + m_vy + 3 >= 360) ns = IDLE;
                BLOCK: if (!down(KEYB)) ns = IDLE;
                default: begin
                    if (nt > 1) nt--;
                    else if (m_st == PUNCH || m_st == KICK) begin ns = COOLDOWN; nt = 6; end
                    else begin ns = IDLE; nt = 0; end
                end
            endcase
        end

        want = (down(KEYR) ? 3 : 0) - (down(KEYL) ? 3 : 0);
        gap = m_x - int'($signed(opp_x));
        vov = iabs(m_y - int'($signed(opp_y))) < 150;
        free_mv = ns == IDLE || ns == WALK || ns == AIR || ns == COOLDOWN;
        d = 0;
        if (!freeze) begin
            if (ns == KNOCK || (free_mv && vov && iabs(gap) < 90))
                d = gap >= 0 ? 3 : -3;
            else if (free_mv) begin
                d = want;
                if (d * gap < 0 && vov && iabs(gap + d) < 90) d = 0;
            end
        end
        nx = m_x + d;
        if (nx < 48) nx = 48;
        if (nx > 504) nx = 504;
        if (freeze) nx = m_x;

        if (freeze) m_vy = 0;
        else if (m_st == AIR) begin
            v = m_vy + 3;
            if (m_y + v >= 360) begin m_y = 360; m_vy = 0; end
            else begin m_y = m_y + v; m_vy = v; end
        end else if (ns == AIR) begin
            m_vy = -30; m_y = m_y - 30;
        end

        m_vel = nx - m_x;
        m_x = nx;
        if (ns == IDLE || ns == WALK || ns == AIR)
            m_face = int'($signed(opp_x)) > m_x;
        m_st = ns; m_tmr = nt;
    endtask

    always @(posedge clk) begin
        if (!Reset_n) model_reset();
        else model_step();
        #1;
        chk("pos_x", pos_x, m_x);
        chk("pos_y", pos_y, m_y);
        chk("vel_x", vel_x, m_vel);
        chk("face_right", face_right, m_face);
        chk("state", state, int'(m_st));
        chk("punch_flag", punch_flag, m_st == PUNCH);
        chk("kick_flag", kick_flag, m_st == KICK);
        chk("block_flag", block_flag, m_st == BLOCK);
        chk("hit_active", hit_active,
            (m_st == PUNCH && m_tmr <= 4) || (m_st == KICK && m_tmr <= 6));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 9))
            0: return 8'h00;
            1: return KEYJ;
            2, 3: return KEYL;
            4, 5: return KEYR;
            6: return KEYP;
            7: return KEYK;
            8: return KEYB;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pf, ha, cd, mx, sx0;
        Reset_n = 0; freeze = 0; hit_in = 0;
        keycode = 0; keycode2 = 0;
        opp_x = 10'd480; opp_y = 10'd360;
        tick(2);
        chk("rst pos_x", pos_x, 150);
        chk("rst pos_y", pos_y, 360);
        chk("rst state", state, 0);
        chk("rst flags", {punch_flag, kick_flag, block_flag, hit_active}, 0);
        chk("rst face", face_right, 1);
        Reset_n = 1;

        keycode = KEYR;
        tick(10);
        chk("walk pos_x", pos_x, 180);
        chk("walk vel_x", vel_x, 3);
        keycode = 0;
        tick(1);

        keycode = KEYJ;
        tick(1);
        keycode = 0;
        chk("jump f1 y", pos_y, 330);
        tick(9);
        chk("jump f10 y", pos_y, 195);
        tick(10);
        chk("jump f20 y", pos_y, 330);
        tick(1);
        chk("land y", pos_y, 360);
        chk("land state", state, 0);

        pf = 0; ha = 0; cd = 0;
        keycode = KEYP;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            pf += punch_flag;
            ha += hit_active;
            cd += (state == 3'd6);
        end
        keycode = 0;
        tick(1);
        chk("punch frames", pf, 8);
        chk("hit frames", ha, 4);
        chk("cooldown frames", cd, 6);
        chk("after cooldown", state, 0);

        Reset_n = 0; opp_x = 10'd250;
        tick(1);
        Reset_n = 1;
        keycode = KEYR;
        mx = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (pos_x > mx) mx = pos_x;
        end
        chk("opp max_x<=160", mx <= 160, 1);
        chk("opp stop x", pos_x, 159);

        keycode = KEYK;
        tick(1);
        keycode = 0;
        tick(4);
        chk("kick state", state, 4);
        sx0 = pos_x;
        freeze = 1;
        tick(1);
        chk("frz state", state, 0);
        chk("frz flags", {punch_flag, kick_flag, block_flag, hit_active}, 0);
        chk("frz pos_x", pos_x, sx0);
        freeze = 0;
        tick(1);

`ifdef FIGHTER_KNOCKBACK_EN
        sx0 = pos_x; cd = 0;
        hit_in = 1;
        tick(1);
        hit_in = 0;
        cd += (state == 3'd7);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            cd += (state == 3'd7);
        end
        chk("knock frames", cd, 6);
        chk("knock disp", pos_x, sx0 - 18);
`endif

        opp_x = 10'd60;
        keycode = KEYR;
        tick(130);
        chk("wall x", pos_x, 504);
        chk("wall vel", vel_x, 0);
        chk("wall face", face_right, 0);
        keycode = 0;

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) keycode = pick();
            if ($urandom_range(0, 5) == 0) keycode2 = pick();
            freeze = ($urandom_range(0, 49) == 0);
            Reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 63) == 0) opp_x = 10'($urandom_range(60, 490));
            if ($urandom_range(0, 63) == 0)
                case ($urandom_range(0, 2))
                    0: opp_y = 10'd360;
                    1: opp_y = 10'd300;
                    default: opp_y = 10'd100;
                endcase
            hit_in = ($urandom_range(0, 39) == 0);
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
